bus_arbiter: RTL and testbench

- Shares the system bus between multiple bus masters, such as the DMA and future peripherals, using a bus_req/bus_grant handshake.
- Arbitrates round-robin and inserts one dead cycle between owners to avoid tri-state contention.
- Contains the bus watchdog: if a granted transfer sees no fc_bus acknowledge within TIMEOUT cycles, it pulses watchdog and revokes the grant.
- Sits at top level next to the address decoder; it observes rd_bus, wr_bus and fc_bus but never drives them.

---
 rtl/bus_arbiter_pkg.sv | 42 ++++
 rtl/bus_watchdog.sv | 40 ++++
 rtl/bus_arbiter.sv | 110 +++++++++++
 tb/tb_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and the round-robin search used by the bus arbiter.
// Supports up to MAX_MASTERS requesters.
package bus_arbiter_pkg;

    localparam int MAX_MASTERS = 16;
    localparam int IDX_W       = $clog2(MAX_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // The search starts one past the previous owner so every requester eventually gets a turn.
    function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                      input int                     last,
                                      input int                     n);
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int off = 1; off <= MAX_MASTERS; off++) begin
            if (off <= n && !res.found) begin
                cand = last + off;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (req[cand[IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Per-access bus timeout: pulses once when a transfer has stalled for TIMEOUT
// consecutive cycles without an acknowledge.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic watchdog
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;
    logic          r_pulse;

    // The counter restarts on every idle or acknowledged cycle, and again after firing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_pulse <= 1'b0;
        end else if (active) begin
            if (r_count == CW'(TIMEOUT - 1)) begin
                r_count <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
                r_pulse <= 1'b0;
            end
        end else begin
            r_count <= '0;
            r_pulse <= 1'b0;
        end
    end

    assign watchdog = r_pulse;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with a dead cycle between owners and a
// watchdog that revokes and locks out a stalled owner.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         bus_req,
    output logic [NUM_MASTERS-1:0]         bus_grant,
    input  logic                           rd_bus,
    input  logic                           wr_bus,
    input  logic                           fc_bus,
    output logic                           watchdog,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           busy
);

    localparam int OW = $clog2(NUM_MASTERS);

    arb_state_t             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [OW-1:0]          r_owner;
    logic [OW-1:0]          r_lastOwner;
    logic [NUM_MASTERS-1:0] r_lockout;

    arb_state_t             w_stateNext;
    logic [NUM_MASTERS-1:0] w_grantNext;
    logic [OW-1:0]          w_ownerNext;
    logic [OW-1:0]          w_lastNext;
    logic [NUM_MASTERS-1:0] w_lockoutNext;
    logic [NUM_MASTERS-1:0] w_eligible;
    logic [MAX_MASTERS-1:0] w_reqPad;
    pick_t                  w_pick;
    logic                   w_active;

    assign w_eligible = bus_req & ~r_lockout;

    always_comb begin
        w_reqPad                = '0;
        w_reqPad[NUM_MASTERS-1:0] = w_eligible;
    end

    assign w_pick   = rr_pick(w_reqPad, int'(r_lastOwner), NUM_MASTERS);
    assign w_active = (r_state == ST_GRANT) && (rd_bus || wr_bus) && !fc_bus;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active   (w_active),
        .watchdog (watchdog)
    );

    // Lockout clears whenever a request is seen low; a timeout on the owner sets it and wins.
    always_comb begin
        w_stateNext   = r_state;
        w_grantNext   = r_grant;
        w_ownerNext   = r_owner;
        w_lastNext    = r_lastOwner;
        w_lockoutNext = r_lockout & bus_req;
        case (r_state)
            ST_GRANT: begin
                if (watchdog) begin
                    w_grantNext            = '0;
                    w_lockoutNext[r_owner] = 1'b1;
                    w_stateNext            = ST_RELEASE;
                end else if (!bus_req[r_owner]) begin
                    w_grantNext = '0;
                    w_stateNext = ST_RELEASE;
                end
            end
            default: begin
                if (w_pick.found) begin
                    w_grantNext = NUM_MASTERS'(1) << w_pick.idx[OW-1:0];
                    w_ownerNext = w_pick.idx[OW-1:0];
                    w_lastNext  = w_pick.idx[OW-1:0];
                    w_stateNext = ST_GRANT;
                end else begin
                    w_grantNext = '0;
                    w_stateNext = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_lastOwner <= OW'(NUM_MASTERS - 1);
            r_lockout   <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_grant     <= w_grantNext;
            r_owner     <= w_ownerNext;
            r_lastOwner <= w_lastNext;
            r_lockout   <= w_lockoutNext;
        end
    end

    assign bus_grant = r_grant;
    assign owner     = r_owner;
    assign busy      = |r_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run
// compared against a tenure-level reference model.
module tb_bus_arbiter;

    localparam int NM = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       rd  = 1'b0;
    logic       wr  = 1'b0;
    logic       fc  = 1'b0;
    logic [3:0] grant;
    logic       wd;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         mOwner;
    int         mLast;
    int         mOwnerOut;
    int         mStall;
    logic       mWd;
    logic [3:0] mLock;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (req),
        .bus_grant (grant),
        .rd_bus    (rd),
        .wr_bus    (wr),
        .fc_bus    (fc),
        .watchdog  (wd),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: an owner index (-1 when the bus floats), a stall run length,
    // and a set of masters barred until they withdraw their request.
    task automatic modelStep();
        logic [3:0] elig;
        logic       newWd;
        if (!rst) begin
            mOwner    = -1;
            mLast     = NM - 1;
            mOwnerOut = 0;
            mStall    = 0;
            mWd       = 1'b0;
            mLock     = 4'b0000;
            return;
        end
        elig  = req & ~mLock;
        newWd = 1'b0;
        if (mOwner >= 0 && (rd || wr) && !fc) begin
            mStall++;
            if (mStall == TO) begin
                newWd  = 1'b1;
                mStall = 0;
            end
        end else begin
            mStall = 0;
        end
        mLock = mLock & req;
        if (mOwner >= 0) begin
            if (mWd) begin
                mLock[mOwner] = 1'b1;
                mOwner        = -1;
            end else if (!req[mOwner]) begin
                mOwner = -1;
            end
        end else begin
            for (int k = 1; k <= NM; k++) begin
                int cand;
                cand = (mLast + k) % NM;
                if (elig[cand]) begin
                    mOwner    = cand;
                    mLast     = cand;
                    mOwnerOut = cand;
                    break;
                end
            end
        end
        mWd = newWd;
    endtask

    function automatic logic [3:0] modelGrant();
        logic [3:0] g;
        g = 4'b0000;
        if (mOwner >= 0) g[mOwner] = 1'b1;
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b0;
        req = 4'b0000;
        rd  = 1'b0;
        wr  = 1'b0;
        fc  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b want %b", grant, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (wd !== 1'b0) begin errors++; $display("[TB] FAIL reset_watchdog: got %b want 0", wd); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d want 0", owner); end
    endtask

    task automatic test_single();
        applyReset();
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL single_grant: got %b want %b", grant, 4'b0010); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
        checks++;
        if (owner !== 2'd1) begin errors++; $display("[TB] FAIL single_owner: got %0d want 1", owner); end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_release: got %b want %b", grant, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy); end
        checks++;
        if (owner !== 2'd1) begin errors++; $display("[TB] FAIL single_owner_hold: got %0d want 1", owner); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        applyReset();
        req = 4'b1111;
        for (int m = 0; m < NM; m++) begin
            want    = 4'b0000;
            want[m] = 1'b1;
            tick();
            checks++;
            if (grant !== want) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", m, grant, want); end
            tick();
            checks++;
            if (grant !== want) begin errors++; $display("[TB] FAIL rr_hold%0d: got %b want %b", m, grant, want); end
            req[m] = 1'b0;
            tick();
            checks++;
            if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL rr_gap%0d: got %b want %b", m, grant, 4'b0000); end
        end
    endtask

    task automatic test_no_preempt();
        applyReset();
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL np_grant2: got %b want %b", grant, 4'b0100); end
        req = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL np_hold: got %b want %b", grant, 4'b0100); end
        end
        req = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL np_gap: got %b want %b", grant, 4'b0000); end
        tick();
        checks++;
        if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL np_grant3: got %b want %b", grant, 4'b1000); end
        checks++;
        if (owner !== 2'd3) begin errors++; $display("[TB] FAIL np_owner3: got %0d want 3", owner); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_watchdog();
        applyReset();
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL wd_grant: got %b want %b", grant, 4'b0001); end
        rd = 1'b1;
        for (int k = 1; k < TO; k++) begin
            tick();
            checks++;
            if (wd !== 1'b0) begin errors++; $display("[TB] FAIL wd_early%0d: got %b want 0", k, wd); end
        end
        tick();
        checks++;
        if (wd !== 1'b1) begin errors++; $display("[TB] FAIL wd_fire: got %b want 1", wd); end
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL wd_grant_at_fire: got %b want %b", grant, 4'b0001); end
        tick();
        checks++;
        if (wd !== 1'b0) begin errors++; $display("[TB] FAIL wd_one_cycle: got %b want 0", wd); end
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL wd_revoke: got %b want %b", grant, 4'b0000); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL wd_lockout: got %b want %b", grant, 4'b0000); end
        end
        rd  = 1'b0;
        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL wd_regrant: got %b want %b", grant, 4'b0001); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fc_keepalive();
        applyReset();
        req = 4'b0001;
        tick();
        rd = 1'b1;
        for (int c = 0; c < 100; c++) begin
            fc = (c % 5 == 4);
            tick();
            checks++;
            if (wd !== 1'b0 || grant !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL fc_keepalive c=%0d: got wd=%b grant=%b want wd=0 grant=0001", c, wd, grant);
            end
        end
        rd  = 1'b0;
        fc  = 1'b0;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        applyReset();
        req = 4'b1010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL rm_grant: got %b want %b", grant, 4'b0010); end
        rd = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0000 || wd !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rm_reset: got grant=%b wd=%b busy=%b owner=%0d want 0000 0 0 0", grant, wd, busy, owner);
        end
        rst = 1'b1;
        rd  = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL rm_regrant: got %b want %b", grant, 4'b0010); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        applyReset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NM; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            rd  = ($urandom_range(0, 9) < 8);
            wr  = ($urandom_range(0, 9) < 2);
            fc  = ($urandom_range(0, 12) == 0);
            rst = ($urandom_range(0, 149) != 0);
            tick();
            checks++;
            if (grant !== modelGrant() || wd !== mWd || busy !== (mOwner >= 0) || owner !== 2'(mOwnerOut)) begin
                errors++;
                $display("[TB] FAIL random c=%0d: got grant=%b wd=%b busy=%b owner=%0d want grant=%b wd=%b busy=%b owner=%0d",
                         c, grant, wd, busy, owner, modelGrant(), mWd, (mOwner >= 0), mOwnerOut);
            end
        end
        rst = 1'b1;
        req = 4'b0000;
        rd  = 1'b0;
        wr  = 1'b0;
        fc  = 1'b0;
        tick();
    endtask

    initial begin
        mOwner    = -1;
        mLast     = NM - 1;
        mOwnerOut = 0;
        mStall    = 0;
        mWd       = 1'b0;
        mLock     = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_watchdog();
        test_fc_keepalive();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
